// File: rtl/meta_write_arbiter_pkg.sv
// Shared types for the metadata write arbiter: request layout and coherence-state encoding.
package meta_write_arbiter_pkg;

  localparam int COH_W     = 2;
  localparam int IDX_W_DEF = 6;
  localparam int WAYS_DEF  = 8;
  localparam int TAG_W_DEF = 20;

  typedef enum logic [COH_W-1:0] {
    COH_INVALID   = 2'd0,
    COH_SHARED    = 2'd1,
    COH_EXCLUSIVE = 2'd2,
    COH_DIRTY     = 2'd3
  } coh_state_e;

  // Canonical request layout at the default widths; the top builds the same
  // field order at its own parameterised widths.
  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic [WAYS_DEF-1:0]  way_en;
    logic [COH_W-1:0]     coh_state;
    logic [TAG_W_DEF-1:0] tag;
  } meta_write_req_t;

endpackage

// File: rtl/meta_write_arbiter_if.sv
// Valid/ready metadata-write channel. A transfer happens only on a rising edge
// where valid and ready are both high; bits are stable whenever valid is high.
interface meta_write_arbiter_if
  import meta_write_arbiter_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int WAYS  = 8,
  parameter int TAG_W = 20
);

  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] bits_idx;
  logic [WAYS-1:0]  bits_way_en;
  logic [COH_W-1:0] bits_data_coh_state;
  logic [TAG_W-1:0] bits_data_tag;

  modport master (
    output valid, bits_idx, bits_way_en, bits_data_coh_state, bits_data_tag,
    input  ready
  );

  modport slave (
    input  valid, bits_idx, bits_way_en, bits_data_coh_state, bits_data_tag,
    output ready
  );

endinterface

// File: rtl/meta_write_arbiter_pipe_reg.sv
// Single-entry valid/ready register slot; accepts a new entry in the same cycle
// the current one drains, so one request per cycle is sustained.
module meta_write_pipe_reg
  import meta_write_arbiter_pkg::*;
#(
  parameter type T = meta_write_req_t
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      // Payload is left untouched when the slot empties.
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/meta_write_arbiter.sv
// Two-input metadata write arbiter: in0 has priority, in1 is force-granted after
// STARVE_LIMIT cycles of losing to in0; output is a single registered slot.
module meta_write_arbiter
  import meta_write_arbiter_pkg::*;
#(
  parameter int IDX_W        = 6,
  parameter int WAYS         = 8,
  parameter int TAG_W        = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  meta_write_arbiter_if.slave  io_in_0,
  meta_write_arbiter_if.slave  io_in_1,
  meta_write_arbiter_if.master io_out,
  output logic io_starve_active
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way_en;
    logic [COH_W-1:0] coh_state;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             force1;
  logic             grant0;
  logic             grant1;
  logic             pipe_ready;
  logic             fire0;
  logic             fire1;
  req_t             in0_req;
  req_t             in1_req;
  req_t             win_req;
  req_t             out_req;

  assign in0_req = '{idx: io_in_0.bits_idx, way_en: io_in_0.bits_way_en,
                     coh_state: io_in_0.bits_data_coh_state, tag: io_in_0.bits_data_tag};
  assign in1_req = '{idx: io_in_1.bits_idx, way_en: io_in_1.bits_way_en,
                     coh_state: io_in_1.bits_data_coh_state, tag: io_in_1.bits_data_tag};

  assign force1 = (starve_cnt == CNT_MAX) & io_in_1.valid;
  assign grant1 = force1 | (~io_in_0.valid & io_in_1.valid);
  assign grant0 = ~grant1 & io_in_0.valid;

  // Readies are held low while reset is asserted so nothing is accepted mid-reset.
  assign io_in_0.ready = reset & pipe_ready & grant0;
  assign io_in_1.ready = reset & pipe_ready & grant1;
  assign fire0         = io_in_0.valid & io_in_0.ready;
  assign fire1         = io_in_1.valid & io_in_1.ready;
  assign win_req       = grant1 ? in1_req : in0_req;

  assign io_starve_active = force1;

  // Only cycles where in1 actually lost to in0 count as starvation.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!io_in_1.valid || fire1) begin
      starve_cnt_nxt = '0;
    end else if (pipe_ready && grant0 && (starve_cnt != CNT_MAX)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end

  meta_write_pipe_reg #(
    .T (req_t)
  ) u_pipe_reg (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (fire0 | fire1),
    .in_ready  (pipe_ready),
    .in_data   (win_req),
    .out_valid (io_out.valid),
    .out_ready (io_out.ready),
    .out_data  (out_req)
  );

  assign io_out.bits_idx            = out_req.idx;
  assign io_out.bits_way_en         = out_req.way_en;
  assign io_out.bits_data_coh_state = out_req.coh_state;
  assign io_out.bits_data_tag       = out_req.tag;

endmodule

// File: tb/tb_meta_write_arbiter.sv
// Directed bench for meta_write_arbiter: a table of back-to-back vectors plus
// hand-written sequences for starvation, back-pressure and async reset.
module tb_meta_write_arbiter;

  localparam logic [19:0] T0 = 20'h11111;
  localparam logic [19:0] T1 = 20'h22222;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [5:0] exp_q[$];

  meta_write_arbiter_if #(.IDX_W(6), .WAYS(8), .TAG_W(20)) in0_if ();
  meta_write_arbiter_if #(.IDX_W(6), .WAYS(8), .TAG_W(20)) in1_if ();
  meta_write_arbiter_if #(.IDX_W(6), .WAYS(8), .TAG_W(20)) out_if ();
  logic starve_active;

  meta_write_arbiter #(
    .IDX_W(6), .WAYS(8), .TAG_W(20), .STARVE_LIMIT(4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io_in_0          (in0_if),
    .io_in_1          (in1_if),
    .io_out           (out_if),
    .io_starve_active (starve_active)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v0;
    logic        v1;
    logic        ordy;
    logic        r0;
    logic        r1;
    logic        st;
    logic        ov;
    logic [19:0] tag;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v0, input logic v1, input logic ordy);
    in0_if.valid = v0;
    in1_if.valid = v1;
    out_if.ready = ordy;
  endtask

  // Leaves reset deasserted at a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    in0_if.bits_idx = 6'h05; in0_if.bits_way_en = 8'h01;
    in0_if.bits_data_coh_state = 2'd1; in0_if.bits_data_tag = T0;
    in1_if.bits_idx = 6'h2A; in1_if.bits_way_en = 8'h80;
    in1_if.bits_data_coh_state = 2'd2; in1_if.bits_data_tag = T1;

    //            v0 v1 ordy r0 r1 st ov tag cnt
    vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 20'h0, 0};
    vecs[1]  = '{1, 0, 1, 1, 0, 0, 1, T0, 0};
    vecs[2]  = '{0, 1, 1, 0, 1, 0, 1, T1, 0};
    vecs[3]  = '{1, 1, 1, 1, 0, 0, 1, T0, 1};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 1, T0, 1};
    vecs[5]  = '{1, 1, 1, 1, 0, 0, 1, T0, 2};
    vecs[6]  = '{1, 1, 1, 1, 0, 0, 1, T0, 3};
    vecs[7]  = '{1, 1, 1, 1, 0, 0, 1, T0, 4};
    vecs[8]  = '{1, 1, 1, 0, 1, 1, 1, T1, 0};
    vecs[9]  = '{0, 0, 1, 0, 0, 0, 0, T1, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, T1, 0};
    vecs[11] = '{1, 0, 0, 1, 0, 0, 1, T0, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 0, 1, T0, 0};
    vecs[13] = '{0, 1, 1, 0, 1, 0, 1, T1, 0};

    // readies low and output empty while reset is held
    in0_if.valid = 1'b1;
    in1_if.valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready0", 32'(in0_if.ready), 32'd0);
    check("rst_ready1", 32'(in1_if.ready), 32'd0);
    check("rst_out_valid", 32'(out_if.valid), 32'd0);
    check("rst_tag", 32'(out_if.bits_data_tag), 32'd0);
    check("rst_cnt", 32'(dut.starve_cnt), 32'd0);

    // table vectors, back to back from reset
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_ready0", i), 32'(in0_if.ready), 32'(vecs[i].r0));
      check($sformatf("v%0d_ready1", i), 32'(in1_if.ready), 32'(vecs[i].r1));
      check($sformatf("v%0d_starve", i), 32'(starve_active), 32'(vecs[i].st));
      cycle();
      check($sformatf("v%0d_out_valid", i), 32'(out_if.valid), 32'(vecs[i].ov));
      check($sformatf("v%0d_tag", i), 32'(out_if.bits_data_tag), 32'(vecs[i].tag));
      check($sformatf("v%0d_cnt", i), 32'(dut.starve_cnt), 32'(vecs[i].cnt));
    end

    // both valid continuously: in0 x4 then forced in1, repeating
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back(6'h05);
      exp_q.push_back(6'h2A);
    end
    drive(1'b1, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      #1;
      check("rr_starve", 32'(starve_active), 32'(e == 6'h2A));
      cycle();
      check("rr_idx", 32'(out_if.bits_idx), 32'(e));
    end

    // only in1 valid: one output per cycle, counter stays clear
    apply_reset();
    in1_if.bits_data_tag = 20'hABCDE;
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("in1_only_valid", 32'(out_if.valid), 32'd1);
      check("in1_only_tag", 32'(out_if.bits_data_tag), 32'hABCDE);
      check("in1_only_cnt", 32'(dut.starve_cnt), 32'd0);
    end
    check("in1_only_idx", 32'(out_if.bits_idx), 32'h2A);
    check("in1_only_way", 32'(out_if.bits_way_en), 32'h80);
    check("in1_only_coh", 32'(out_if.bits_data_coh_state), 32'd2);
    in1_if.bits_data_tag = T1;

    // back-pressure: output stalled 3 cycles holds data and counter
    apply_reset();
    drive(1'b1, 1'b1, 1'b1);
    cycle();
    cycle();
    check("bp_pre_cnt", 32'(dut.starve_cnt), 32'd2);
    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", 32'(in0_if.ready), 32'd0);
      check("bp_ready1", 32'(in1_if.ready), 32'd0);
      cycle();
      check("bp_valid", 32'(out_if.valid), 32'd1);
      check("bp_tag", 32'(out_if.bits_data_tag), 32'(T0));
      check("bp_cnt", 32'(dut.starve_cnt), 32'd2);
    end
    out_if.ready = 1'b1;
    #1;
    check("bp_ready0_return", 32'(in0_if.ready), 32'd1);
    cycle();
    check("bp_cnt_after", 32'(dut.starve_cnt), 32'd3);

    // in1 drops after 2 stalls: counter clears, forced grant needs 4 fresh stalls
    apply_reset();
    drive(1'b1, 1'b1, 1'b1);
    cycle();
    cycle();
    check("drop_pre_cnt", 32'(dut.starve_cnt), 32'd2);
    in1_if.valid = 1'b0;
    cycle();
    check("drop_cnt", 32'(dut.starve_cnt), 32'd0);
    in1_if.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fresh_no_starve", 32'(starve_active), 32'd0);
      cycle();
    end
    #1;
    check("fresh_starve", 32'(starve_active), 32'd1);
    check("fresh_ready1", 32'(in1_if.ready), 32'd1);
    cycle();
    check("fresh_tag", 32'(out_if.bits_data_tag), 32'(T1));

    // async reset mid-cycle with output full
    apply_reset();
    drive(1'b1, 1'b1, 1'b1);
    cycle();
    check("ar_pre_valid", 32'(out_if.valid), 32'd1);
    check("ar_pre_cnt", 32'(dut.starve_cnt), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(out_if.valid), 32'd0);
    check("ar_cnt", 32'(dut.starve_cnt), 32'd0);
    check("ar_tag", 32'(out_if.bits_data_tag), 32'd0);
    check("ar_ready0", 32'(in0_if.ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cycle();
    check("ar_first_valid", 32'(out_if.valid), 32'd1);
    check("ar_first_tag", 32'(out_if.bits_data_tag), 32'(T0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
